scs8hd_o31an_pipe: RTL and testbench
====================================

Name: scs8hd_o31an_pipe

Overview:
Parametrised, multi-channel successor to the fixed 3-input OR / AND cell. Each channel computes X[c] = (A[c][0] | … | A[c][NA-1]) & B[c], optionally inverted per transaction. Results are registered into a valid/ready output queue with occupancy reporting and a saturating "any-hit" counter. It sits between ungated combinational request logic and a downstream consumer that may stall.

Parameters:
NCH, 4, number of independent OR-AND channels (≥1)
NA, 3, OR-input count per channel (≥1; NA=3 reproduces the 3-input OR / AND function)
DEPTH, 2, output queue entries (power of two, ≥2)
CNTW, 8, hit counter width (≥1)

Ports:
CLK  input  1  rising-edge clock
RESETB  input  1  asynchronous active-low reset
A  input  NCH*NA  OR inputs; channel c uses bits [c*NA +: NA]
B  input  NCH  per-channel AND input
mode  input  1  0 = non-inverted (OR-AND), 1 = inverted (OR-AND-INVERT); sampled on accept
in_valid  input  1  A/B/mode valid this cycle
in_ready  output  1  block can accept
X  output  NCH  head-of-queue result
out_valid  output  1  X valid
out_ready  input  1  consumer accepts X
level  output  $clog2(DEPTH)+1  current queue occupancy
cnt_clr  input  1  synchronous clear of hit_cnt
hit_cnt  output  CNTW  popped results with X≠0, saturating
vpwr, vgnd, vpb, vnb  input  1 each  present only under SC_USE_PG_PIN; supply1/supply0 otherwise; no functional effect

Behaviour:
- Reset (RESETB low, asynchronous): queue emptied, pointers 0, out_valid=0, X=0, level=0, hit_cnt=0. in_ready=1 while held and after release. Reset mid-operation discards all queued entries, with no partial pop.
- Accept: in_valid & in_ready at a rising edge. The result vector r[c] = (|A[c]) & B[c]; if mode=1, r[c] is inverted. r is written at the tail; tail advances mod DEPTH.
- in_ready = (level != DEPTH). It is a registered-state function only, with no combinational path from out_ready.
- Latency: data accepted at edge k appears on X with out_valid=1 immediately after edge k, if the queue was empty. Otherwise it appears in FIFO order.
- Pop: out_valid & out_ready at a rising edge; head advances mod DEPTH.
- X = head entry when out_valid=1; X is all zeros when out_valid=0.
- out_valid = (level != 0).
- Simultaneous push and pop (0<level<DEPTH): both occur and level is unchanged.
  - Full: no push occurs (in_ready=0); a pop is allowed, and in_ready rises the following cycle.
  - Empty: no pop occurs (out_valid=0); the push proceeds.
- Inputs are ignored when in_valid=0. A, B and mode may change freely without a handshake.
- hit_cnt:
  - Increments by 1 on each pop whose X is non-zero.
  - Saturates at 2^CNTW-1 and never wraps.
  - cnt_clr=1 forces 0 at the next edge, with priority over a coincident increment.
- All outputs are glitch-free registered state, except X, which is a mux of registered entries selected by the registered head pointer.

Decomposition:
- Package scs8hd_o31an_pkg:
  - MODE_OA=1'b0, MODE_OAI=1'b1 constants.
  - Pure function or_and(a_vec, b) returning one channel result.
  - Localparam helper for pointer width.
- Sub-module scs8hd_o31an_fifo holds the storage, pointers, level, full/empty and the push/pop arbitration. It is parametrised by width NCH and DEPTH. The top level holds the per-channel OR-AND generate loop, mode inversion and hit counter.

Test Plan:
1. Reset then defaults (NCH=4, NA=3): after RESETB release → in_ready=1, out_valid=0, X=4'h0, level=0, hit_cnt=0.
2. Single transaction: channel 0 A=3'b010, B=1; channel 1 A=3'b000, B=1; channel 2 A=3'b111, B=0; channel 3 A=3'b100, B=1; mode=0; in_valid 1 cycle with out_ready=0 → next cycle X=4'b1001, out_valid=1, level=1. Then pulse out_ready → out_valid=0, hit_cnt=1.
3. Back-pressure (DEPTH=2): push 3 consecutive beats with out_ready=0 → in_ready drops after beat 2 and beat 3 is held off. Raise out_ready → beats pop in order, in_ready=1 after the first pop, and all 3 beats are delivered exactly once.
4. Inverted mode: all A=0 with mode=1 → X=4'hF. Pop it → hit_cnt increments. All-ones inputs with mode=1 → X=0, and its pop does not increment hit_cnt.
5. Saturation and clear (CNTW=2): pop 5 non-zero results → hit_cnt=3 and held. cnt_clr coincident with a non-zero pop → hit_cnt=0.
6. Asynchronous reset mid-stream: level=2 and RESETB pulsed low between clock edges → out_valid=0 and level=0 immediately, without waiting for an edge; no stale X after release.

Source files
------------

// File: rtl/scs8hd_o31an_pkg.sv
// -----------------------------------------------------------------------------
// scs8hd_o31an_pkg
//   Shared constants and helpers for the multi-channel OR-AND pipe.
//   - MODE_OA / MODE_OAI : values of the per-transaction mode bit
//   - OR_MAX_W           : widest OR group the or_and() helper accepts
//   - ptr_w()            : pointer width for a queue of a given depth
//   - or_and()           : one channel result, (|a_vec) & b
// -----------------------------------------------------------------------------
package scs8hd_o31an_pkg;

  // Mode encodings: OA drives the plain OR-AND result, OAI drives its inverse.
  localparam logic MODE_OA  = 1'b0;
  localparam logic MODE_OAI = 1'b1;

  // The OR group is zero-extended to this width before reduction, so one
  // helper serves every NA up to this bound.
  localparam int OR_MAX_W = 32;

  // Pointer width for a power-of-two queue; never below one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One channel: OR of the (zero-extended) group, gated by b.
  function automatic logic or_and(input logic [OR_MAX_W-1:0] a_vec,
                                  input logic                b);
    return (|a_vec) & b;
  endfunction

endpackage

// File: rtl/scs8hd_o31an_fifo.sv
// -----------------------------------------------------------------------------
// scs8hd_o31an_fifo
//   Result queue for the OR-AND pipe: storage, head/tail pointers, occupancy
//   and push/pop arbitration.
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both 1. Ready never depends on valid of the same interface, and
//   o_push_ready is derived from registered occupancy only, so there is no
//   combinational path from i_pop_ready to o_push_ready.
//
//   Ports
//     clk, rst_n      : clock, asynchronous active-low reset
//     i_push_valid    : producer offers i_push_data
//     o_push_ready    : queue not full
//     i_push_data     : W-bit entry to store at the tail
//     o_pop_valid     : queue not empty
//     i_pop_ready     : consumer takes the head entry
//     o_pop_data      : head entry, forced to zero while empty
//     o_level         : current occupancy, 0..DEPTH
//     o_pop_fire      : a pop happens at the coming edge
// -----------------------------------------------------------------------------
module scs8hd_o31an_fifo
  import scs8hd_o31an_pkg::*;
#(
  parameter int W     = 4,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push_valid,
  output logic                     o_push_ready,
  input  logic [W-1:0]             i_push_data,
  output logic                     o_pop_valid,
  input  logic                     i_pop_ready,
  output logic [W-1:0]             o_pop_data,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_pop_fire
);

  localparam int PW = ptr_w(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [LW-1:0] r_level;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_level == LW'(DEPTH));
  assign w_empty = (r_level == '0);

  // Full blocks the push even if a pop happens in the same cycle; the freed
  // slot is offered one cycle later. Empty blocks the pop, the push proceeds.
  assign w_push = i_push_valid & ~w_full;
  assign w_pop  = i_pop_ready  & ~w_empty;

  // Storage and tail pointer. DEPTH is a power of two, so the pointers wrap
  // naturally at PW bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_tail <= '0;
    end else if (w_push) begin
      r_mem[r_tail] <= i_push_data;
      r_tail        <= r_tail + 1'b1;
    end
  end

  // Head pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
    end else if (w_pop) begin
      r_head <= r_head + 1'b1;
    end
  end

  // Occupancy: unchanged when push and pop coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_push_ready = ~w_full;
  assign o_pop_valid  = ~w_empty;
  assign o_level      = r_level;
  assign o_pop_fire   = w_pop;

  // Head mux selected by the registered head pointer; zeros while empty so a
  // stale entry is never visible downstream.
  assign o_pop_data = w_empty ? '0 : r_mem[r_head];

endmodule

// File: rtl/scs8hd_o31an_pipe.sv
// -----------------------------------------------------------------------------
// scs8hd_o31an_pipe
//   Multi-channel OR-AND(-INVERT) stage with a valid/ready output queue and a
//   saturating count of non-zero results delivered downstream.
//
//   Channel c computes r[c] = (|A[c*NA +: NA]) & B[c], inverted when mode=1.
//   The whole vector is captured as one queue entry on an accepted beat.
//
//   Handshake: a beat transfers on a rising CLK edge where valid and ready are
//   both 1 (in_valid/in_ready on the input side, out_valid/out_ready on the
//   output side). Inputs are don't-care while in_valid=0.
//
//   Ports
//     CLK, RESETB   : clock, asynchronous active-low reset
//     A             : OR inputs, NCH groups of NA bits
//     B             : per-channel AND input
//     mode          : 0 = OR-AND, 1 = OR-AND-INVERT, captured with the beat
//     in_valid      : A/B/mode valid
//     in_ready      : queue has room (registered occupancy only)
//     X             : head-of-queue result, zero while out_valid=0
//     out_valid     : queue not empty
//     out_ready     : consumer takes X
//     level         : queue occupancy
//     cnt_clr       : synchronous clear of hit_cnt, wins over an increment
//     hit_cnt       : popped results with X != 0, saturating
//     vpwr/vgnd/vpb/vnb : supply pins, ports only with SC_USE_PG_PIN
// -----------------------------------------------------------------------------
module scs8hd_o31an_pipe
  import scs8hd_o31an_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int NA    = 3,
  parameter int DEPTH = 2,
  parameter int CNTW  = 8
) (
`ifdef SC_USE_PG_PIN
  input  logic                   vpwr,
  input  logic                   vgnd,
  input  logic                   vpb,
  input  logic                   vnb,
`endif
  input  logic                   CLK,
  input  logic                   RESETB,
  input  logic [NCH*NA-1:0]      A,
  input  logic [NCH-1:0]         B,
  input  logic                   mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [NCH-1:0]         X,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  input  logic                   cnt_clr,
  output logic [CNTW-1:0]        hit_cnt
);

`ifndef SC_USE_PG_PIN
  supply1 vpwr;
  supply0 vgnd;
  supply1 vpb;
  supply0 vnb;
`endif

  // Supply pins carry no function in this model.
  logic w_unused_pg;
  assign w_unused_pg = vpwr ^ vgnd ^ vpb ^ vnb;

  // ---------------------------------------------------------------------------
  // Per-channel OR-AND with optional inversion
  // ---------------------------------------------------------------------------
  logic [NCH-1:0] w_result;
  logic           w_invert;

  assign w_invert = (mode == MODE_OAI);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [OR_MAX_W-1:0] w_a_ext;
    assign w_a_ext     = OR_MAX_W'(A[c*NA +: NA]);
    assign w_result[c] = or_and(w_a_ext, B[c]) ^ w_invert;
  end

  // ---------------------------------------------------------------------------
  // Output queue
  // ---------------------------------------------------------------------------
  logic w_pop_fire;

  scs8hd_o31an_fifo #(
    .W     (NCH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (CLK),
    .rst_n        (RESETB),
    .i_push_valid (in_valid),
    .o_push_ready (in_ready),
    .i_push_data  (w_result),
    .o_pop_valid  (out_valid),
    .i_pop_ready  (out_ready),
    .o_pop_data   (X),
    .o_level      (level),
    .o_pop_fire   (w_pop_fire)
  );

  // ---------------------------------------------------------------------------
  // Hit counter: counts delivered non-zero results, sticks at all-ones
  // ---------------------------------------------------------------------------
  logic [CNTW-1:0] r_hit_cnt;
  logic            w_hit;
  logic            w_cnt_sat;

  assign w_hit     = w_pop_fire & (|X);
  assign w_cnt_sat = &r_hit_cnt;

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      r_hit_cnt <= '0;
    end else if (cnt_clr) begin
      r_hit_cnt <= '0;
    end else if (w_hit && !w_cnt_sat) begin
      r_hit_cnt <= r_hit_cnt + 1'b1;
    end
  end

  assign hit_cnt = r_hit_cnt;

endmodule

// File: tb/tb_scs8hd_o31an_pipe.sv
// -----------------------------------------------------------------------------
// tb_scs8hd_o31an_pipe
//   Directed bench for scs8hd_o31an_pipe with NCH=4, NA=3, DEPTH=2, CNTW=2.
//   The narrow counter makes saturation reachable in a handful of pops.
// -----------------------------------------------------------------------------
module tb_scs8hd_o31an_pipe;

  localparam int NCH   = 4;
  localparam int NA    = 3;
  localparam int DEPTH = 2;
  localparam int CNTW  = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic CLK = 1'b0;
  logic RESETB = 1'b0;
  always #5 CLK = ~CLK;

  logic [NCH*NA-1:0] A = '0;
  logic [NCH-1:0]    B = '0;
  logic              mode = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [NCH-1:0]    X;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [1:0]        level;
  logic              cnt_clr = 1'b0;
  logic [CNTW-1:0]   hit_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [NCH-1:0] exp_q[$];

  scs8hd_o31an_pipe #(
    .NCH   (NCH),
    .NA    (NA),
    .DEPTH (DEPTH),
    .CNTW  (CNTW)
  ) dut (
    .CLK       (CLK),
    .RESETB    (RESETB),
    .A         (A),
    .B         (B),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .cnt_clr   (cnt_clr),
    .hit_cnt   (hit_cnt)
  );

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Advance one edge and settle 1 ns after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_cnt();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  // One accepted beat into an empty queue, left queued.
  task automatic push_one(input logic [NCH*NA-1:0] a, input logic [NCH-1:0] b,
                          input logic m);
    A = a; B = b; mode = m; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    A = $urandom_range(0, 4095);  // inputs are free once the beat is gone
    B = $urandom_range(0, 15);
    mode = $urandom_range(0, 1);
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    RESETB = 1'b0;
    repeat (2) tick();
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_hold_in_ready got=%b exp=1", in_ready);
    end
    #2 RESETB = 1'b1;
    tick();
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || X !== 4'h0 ||
        level !== 2'd0 || hit_cnt !== 2'd0) begin
      n_err++;
      $display("FAIL reset_defaults got in_ready=%b out_valid=%b X=%h level=%0d hit=%0d exp 1 0 0 0 0",
               in_ready, out_valid, X, level, hit_cnt);
    end
  endtask

  task automatic test_single();
    // ch3 A=100 B=1 -> 1, ch2 A=111 B=0 -> 0, ch1 A=000 B=1 -> 0, ch0 A=010 B=1 -> 1
    clear_cnt();
    push_one(12'b100_111_000_010, 4'b1011, 1'b0);
    n_vec++;
    if (X !== 4'b1001 || out_valid !== 1'b1 || level !== 2'd1) begin
      n_err++;
      $display("FAIL single_result got X=%b out_valid=%b level=%0d exp X=1001 1 1",
               X, out_valid, level);
    end
    pop_one();
    n_vec++;
    if (out_valid !== 1'b0 || hit_cnt !== 2'd1 || X !== 4'h0) begin
      n_err++;
      $display("FAIL single_pop got out_valid=%b hit=%0d X=%h exp 0 1 0",
               out_valid, hit_cnt, X);
    end
  endtask

  task automatic test_back_to_back();
    logic [NCH*NA-1:0] beats_a [3];
    logic [NCH-1:0]    beats_x [3];
    beats_a[0] = 12'h001; beats_x[0] = 4'b0001;  // ch0 bit0
    beats_a[1] = 12'h008; beats_x[1] = 4'b0010;  // ch1 bit0
    beats_a[2] = 12'h040; beats_x[2] = 4'b0100;  // ch2 bit0
    clear_cnt();
    exp_q.delete();
    out_ready = 1'b0;
    B = 4'hF; mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      A = beats_a[i]; in_valid = 1'b1;
      if (in_ready) exp_q.push_back(beats_x[i]);
      tick();
    end
    // beat 3 is still offered and must not have entered
    n_vec++;
    if (level !== 2'd2 || in_ready !== 1'b0 || X !== beats_x[0] || exp_q.size() != 2) begin
      n_err++;
      $display("FAIL bp_full got level=%0d in_ready=%b X=%b queued=%0d exp 2 0 0001 2",
               level, in_ready, X, exp_q.size());
    end
    // drain, keeping beat 3 offered until it is accepted
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 8 && (out_valid || in_valid); cyc++) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(beats_x[2]);
      end
      if (out_valid) begin
        n_vec++;
        if (exp_q.size() == 0 || X !== exp_q[0]) begin
          n_err++; $display("FAIL bp_order got X=%b exp=%b", X,
                            (exp_q.size() != 0) ? exp_q[0] : 4'hx);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (cyc == 0) begin
        tick();
        n_vec++;
        if (in_ready !== 1'b1 || level !== 2'd1) begin
          n_err++; $display("FAIL bp_ready_after_pop got in_ready=%b level=%0d exp 1 1",
                            in_ready, level);
        end
      end else begin
        if (in_valid && in_ready) begin
          tick();
          in_valid = 1'b0;
        end else begin
          tick();
        end
      end
    end
    out_ready = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || level !== 2'd0 || exp_q.size() != 0 || in_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_drained got out_valid=%b level=%0d left=%0d in_valid=%b exp 0 0 0 0",
               out_valid, level, exp_q.size(), in_valid);
    end
    in_valid = 1'b0;
    n_vec++;
    if (hit_cnt !== 2'd3) begin
      n_err++; $display("FAIL bp_hits got=%0d exp=3", hit_cnt);
    end
  endtask

  task automatic test_inverted();
    clear_cnt();
    push_one(12'h000, 4'h0, 1'b1);
    n_vec++;
    if (X !== 4'hF || out_valid !== 1'b1) begin
      n_err++; $display("FAIL inv_zero got X=%h out_valid=%b exp F 1", X, out_valid);
    end
    pop_one();
    n_vec++;
    if (hit_cnt !== 2'd1) begin
      n_err++; $display("FAIL inv_zero_hit got=%0d exp=1", hit_cnt);
    end
    push_one(12'hFFF, 4'hF, 1'b1);
    n_vec++;
    if (X !== 4'h0 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL inv_ones got X=%h out_valid=%b exp 0 1", X, out_valid);
    end
    pop_one();
    n_vec++;
    if (hit_cnt !== 2'd1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL inv_ones_hit got hit=%0d out_valid=%b exp 1 0", hit_cnt, out_valid);
    end
  endtask

  task automatic test_saturation();
    logic [CNTW-1:0] exp_hit [5];
    exp_hit[0] = 2'd1; exp_hit[1] = 2'd2; exp_hit[2] = 2'd3;
    exp_hit[3] = 2'd3; exp_hit[4] = 2'd3;
    clear_cnt();
    for (int i = 0; i < 5; i++) begin
      push_one(12'h800, 4'h8, 1'b0);  // ch3 only -> X=1000
      pop_one();
      n_vec++;
      if (hit_cnt !== exp_hit[i]) begin
        n_err++; $display("FAIL sat_pop%0d got=%0d exp=%0d", i, hit_cnt, exp_hit[i]);
      end
    end
    push_one(12'h800, 4'h8, 1'b0);
    cnt_clr = 1'b1;
    pop_one();
    cnt_clr = 1'b0;
    n_vec++;
    if (hit_cnt !== 2'd0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL sat_clr_priority got hit=%0d out_valid=%b exp 0 0", hit_cnt, out_valid);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    B = 4'hF; mode = 1'b0;
    A = 12'h001; in_valid = 1'b1; tick();
    A = 12'h008; tick();
    in_valid = 1'b0;
    n_vec++;
    if (level !== 2'd2 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL arst_setup got level=%0d out_valid=%b exp 2 1", level, out_valid);
    end
    // between edges: posedge+1 -> +3, CLK stays high until +5
    #2 RESETB = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || level !== 2'd0 || X !== 4'h0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL arst_immediate got out_valid=%b level=%0d X=%h in_ready=%b exp 0 0 0 1",
               out_valid, level, X, in_ready);
    end
    #3 RESETB = 1'b1;
    tick();
    tick();
    n_vec++;
    if (out_valid !== 1'b0 || X !== 4'h0 || level !== 2'd0) begin
      n_err++; $display("FAIL arst_no_stale got out_valid=%b X=%h level=%0d exp 0 0 0",
                        out_valid, X, level);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_inverted();
    test_saturation();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
